// File: rtl/decodificador_fifo.sv
`default_nettype none
// ============================================================================
// Module   : decodificador_fifo
// Purpose  : Captures the 4-bit encoder codeword on each synchronised rise of
//            the encoder's ready strobe, applies the inverse nibble map, and
//            queues the result in a first-word-fall-through FIFO that is
//            drained through a valid/ack handshake.
// Revision : 1.0 - initial release
// ============================================================================
module decodificador_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ready,
  input  logic [3:0]                code_in,
  input  logic                      flush,
  input  logic                      clr_ovf,
  output logic [3:0]                data_out,
  output logic                      data_valid,
  input  logic                      data_ack,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      overflow
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   C_DEPTH = (AW+1)'(DEPTH);

  // Synchroniser and edge-qualification state
  logic           r1_q, r2_q, r3_q;
  logic           started_q;
  logic           armed_q;

  // FIFO state
  logic [3:0]     mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q,  count_d;
  logic           ovf_q,    ovf_d;

  // Per-cycle events
  logic           push_evt;
  logic           pop_evt;
  logic           wr_en;
  logic           drop_evt;
  logic           is_full;
  logic           is_empty;

  // Inverse of the encoder's nibble mapping (a bijection, so every code is valid)
  function automatic logic [3:0] decode(input logic [3:0] c);
    case (c)
      4'h0:    decode = 4'h3;
      4'h1:    decode = 4'h4;
      4'h2:    decode = 4'hB;
      4'h3:    decode = 4'h9;
      4'h4:    decode = 4'h6;
      4'h5:    decode = 4'h0;
      4'h6:    decode = 4'hE;
      4'h7:    decode = 4'h8;
      4'h8:    decode = 4'hD;
      4'h9:    decode = 4'h2;
      4'hA:    decode = 4'hF;
      4'hB:    decode = 4'h7;
      4'hC:    decode = 4'h1;
      4'hD:    decode = 4'hA;
      4'hE:    decode = 4'hC;
      default: decode = 4'h5;
    endcase
  endfunction

  // Three-flop synchroniser on ready; armed_q blocks a push until ready has
  // been seen low after reset, so a strobe held high across reset release
  // (or one in flight when reset hit) never produces a push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r1_q      <= 1'b0;
      r2_q      <= 1'b0;
      r3_q      <= 1'b0;
      started_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      r1_q      <= ready;
      r2_q      <= r1_q;
      r3_q      <= r2_q;
      started_q <= 1'b1;
      armed_q   <= armed_q | (started_q & ~r1_q);
    end
  end

  // Event decoding and next-state computation for pointers, count and overflow
  always_comb begin
    is_empty = (count_q == '0);
    is_full  = (count_q == C_DEPTH);
    push_evt = armed_q & r2_q & ~r3_q;
    pop_evt  = ~is_empty & data_ack;
    // A push into a full FIFO is only accepted when a pop frees a slot on the same edge.
    wr_en    = push_evt & (~is_full | pop_evt) & ~flush;
    drop_evt = push_evt & is_full & ~pop_evt & ~flush;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en)   wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_evt) rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_en && !pop_evt)      count_d = count_q + 1'b1;
      else if (!wr_en && pop_evt) count_d = count_q - 1'b1;
    end

    // Set wins over a same-edge clear.
    ovf_d = ovf_q;
    if (clr_ovf)  ovf_d = 1'b0;
    if (drop_evt) ovf_d = 1'b1;
  end

  // Pointer, occupancy and sticky overflow registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array; contents need no reset because the output is masked when empty
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= decode(code_in);
  end

  assign data_out   = is_empty ? 4'h0 : mem_q[rd_ptr_q];
  assign data_valid = ~is_empty;
  assign count      = count_q;
  assign full       = is_full;
  assign overflow   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_decodificador_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_decodificador_fifo
// Purpose  : Self-checking bench for decodificador_fifo: map table sweep plus
//            hand-written latency, overflow, flush and reset sequences, with a
//            queue scoreboard modelling the FIFO contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decodificador_fifo;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       ready;
  logic [3:0] code_in;
  logic       flush;
  logic       clr_ovf;
  logic [3:0] data_out;
  logic       data_valid;
  logic       data_ack;
  logic [2:0] count;
  logic       full;
  logic       overflow;

  decodificador_fifo #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .ready      (ready),
    .code_in    (code_in),
    .flush      (flush),
    .clr_ovf    (clr_ovf),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ack   (data_ack),
    .count      (count),
    .full       (full),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] code;
    logic [3:0] exp;
  } vec_t;

  vec_t       vecs [16];
  logic [3:0] sb [$];
  logic       ovf_m;
  int         n_total;
  int         n_pass;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else
      n_pass++;
  endtask

  // One encoder strobe; ack/flush are applied on the push edge (E3).
  task automatic strobe(input logic [3:0] c, input logic ack, input logic fl);
    code_in = c;
    ready   = 1'b1;
    tick();                         // E1
    tick();                         // E2
    data_ack = ack;
    flush    = fl;
    if (ack && sb.size() > 0) check("head_before_ackpush", {4'h0, data_out}, {4'h0, sb[0]});
    tick();                         // E3: push edge
    data_ack = 1'b0;
    flush    = 1'b0;
    if (fl) begin
      sb.delete();
    end else begin
      if (ack && sb.size() > 0) void'(sb.pop_front());
      if (sb.size() < DEPTH) sb.push_back(vecs[c].exp);
      else                   ovf_m = 1'b1;
    end
    ready = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic pop_check(input string name);
    logic [3:0] e;
    check({name, "_valid"}, {7'h0, data_valid}, 8'h1);
    check({name, "_count"}, {5'h0, count}, 8'(sb.size()));
    e = sb.pop_front();
    check(name, {4'h0, data_out}, {4'h0, e});
    data_ack = 1'b1;
    tick();
    data_ack = 1'b0;
  endtask

  task automatic drain(input string name);
    while (sb.size() > 0) pop_check(name);
    check({name, "_empty_valid"}, {7'h0, data_valid}, 8'h0);
    check({name, "_empty_out"}, {4'h0, data_out}, 8'h0);
  endtask

  initial begin
    logic [3:0] dec_m [16];
    n_total = 0;
    n_pass  = 0;
    ovf_m   = 1'b0;

    dec_m = '{4'h3, 4'h4, 4'hB, 4'h9, 4'h6, 4'h0, 4'hE, 4'h8,
              4'hD, 4'h2, 4'hF, 4'h7, 4'h1, 4'hA, 4'hC, 4'h5};
    for (int i = 0; i < 16; i++) begin
      vecs[i].code = 4'(i);
      vecs[i].exp  = dec_m[i];
    end

    // Reset with random inputs; outputs must stay cleared across clocks
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ready    = 1'($urandom);
      code_in  = 4'($urandom);
      flush    = 1'($urandom);
      clr_ovf  = 1'($urandom);
      data_ack = 1'($urandom);
      tick();
    end
    check("rst_data_out", {4'h0, data_out}, 8'h0);
    check("rst_valid",    {7'h0, data_valid}, 8'h0);
    check("rst_count",    {5'h0, count}, 8'h0);
    check("rst_full",     {7'h0, full}, 8'h0);
    check("rst_overflow", {7'h0, overflow}, 8'h0);

    ready = 0; code_in = 0; flush = 0; clr_ovf = 0; data_ack = 0;
    reset = 1'b1;
    tick(); tick(); tick();

    // Single strobe with exact latency
    code_in = 4'b0101;
    ready   = 1'b1;
    tick();
    check("lat_e1_valid", {7'h0, data_valid}, 8'h0);
    tick();
    check("lat_e2_valid", {7'h0, data_valid}, 8'h0);
    tick();
    check("lat_e3_valid", {7'h0, data_valid}, 8'h1);
    check("lat_e3_out",   {4'h0, data_out}, 8'h0);
    check("lat_e3_count", {5'h0, count}, 8'h1);
    ready = 1'b0;
    tick(); tick(); tick();
    check("single_one_push", {5'h0, count}, 8'h1);
    data_ack = 1'b1;
    tick();
    data_ack = 1'b0;
    check("single_ack_valid", {7'h0, data_valid}, 8'h0);
    check("single_ack_out",   {4'h0, data_out}, 8'h0);

    // Full-map sweep from the vector table
    for (int i = 0; i < 16; i++) begin
      strobe(vecs[i].code, 1'b0, 1'b0);
      check($sformatf("map_%0h", i), {4'h0, data_out}, {4'h0, vecs[i].exp});
      pop_check("map_pop");
    end

    // Overflow: five strobes into a four-entry FIFO
    strobe(4'hC, 0, 0); strobe(4'h9, 0, 0); strobe(4'hA, 0, 0);
    strobe(4'hF, 0, 0); strobe(4'h1, 0, 0);
    check("ovf_full",     {7'h0, full}, 8'h1);
    check("ovf_count",    {5'h0, count}, 8'h4);
    check("ovf_flag",     {7'h0, overflow}, {7'h0, ovf_m});
    drain("ovf_drain");
    check("ovf_sticky",   {7'h0, overflow}, 8'h1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    ovf_m   = 1'b0;
    check("ovf_cleared",  {7'h0, overflow}, 8'h0);

    // Full FIFO with push and pop on the same edge
    strobe(4'hC, 0, 0); strobe(4'h9, 0, 0); strobe(4'hA, 0, 0); strobe(4'hF, 0, 0);
    check("pp_full_before", {7'h0, full}, 8'h1);
    strobe(4'h0, 1'b1, 1'b0);
    check("pp_count",    {5'h0, count}, 8'h4);
    check("pp_overflow", {7'h0, overflow}, {7'h0, ovf_m});
    drain("pp_drain");

    // Flush on a push edge with three entries queued
    strobe(4'h1, 0, 0); strobe(4'h2, 0, 0); strobe(4'h3, 0, 0);
    check("fl_count_before", {5'h0, count}, 8'h3);
    strobe(4'h6, 1'b0, 1'b1);
    check("fl_count", {5'h0, count}, 8'h0);
    check("fl_valid", {7'h0, data_valid}, 8'h0);
    check("fl_out",   {4'h0, data_out}, 8'h0);

    // Reset pulse while a strobe is inside the synchroniser
    strobe(4'h4, 0, 0);
    code_in = 4'h7;
    ready   = 1'b1;
    tick();
    reset = 1'b0;
    #2;
    check("mr_count_async", {5'h0, count}, 8'h0);
    reset = 1'b1;
    sb.delete();
    ovf_m = 1'b0;
    tick(); tick();
    ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("mr_no_push_valid", {7'h0, data_valid}, 8'h0);
    check("mr_no_push_count", {5'h0, count}, 8'h0);
    check("mr_overflow",      {7'h0, overflow}, 8'h0);
    strobe(4'h2, 0, 0);
    drain("mr_recover");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
